// File: rtl/random_digit.sv
// random_digit: pseudo-random decimal digit generator.
//
// A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances on every rising
// clock edge. The low nibble of its next state is folded into 0..9 and
// registered on rnd, so each edge yields a new digit with one cycle of latency.
//
// Parameters:
//   SEED  - LFSR value loaded by reset; a zero seed is replaced by 16'hACE1 so
//           the LFSR never enters its all-zero lock-up state.
// Ports:
//   clk   - clock, all state updates on its rising edge
//   reset - asynchronous, active-high reset
//   rnd   - registered digit, always in 0..9
//
// Optional feature (macro RANDOM_DIGIT_NOREPEAT_EN): when defined, a digit
// equal to the current rnd is bumped to (digit+1) mod 10 so consecutive
// outputs always differ. The LFSR sequence is unaffected.
module random_digit #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] rnd
);

  localparam logic [15:0] LoadValue = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        fb;
  logic [3:0]  cand;
  logic [3:0]  digit;
  logic [3:0]  rnd_next;

  always_comb begin
    fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    lfsr_next = {lfsr[14:0], fb};
    cand      = lfsr_next[3:0];
    // 10..15 fold onto 4..9
    digit     = (cand > 4'd9) ? (cand - 4'd6) : cand;
`ifdef RANDOM_DIGIT_NOREPEAT_EN
    if (digit == rnd) begin
      rnd_next = (digit == 4'd9) ? 4'd0 : (digit + 4'd1);
    end else begin
      rnd_next = digit;
    end
`else
    rnd_next  = digit;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LoadValue;
      rnd  <= 4'd0;
    end else begin
      lfsr <= lfsr_next;
      rnd  <= rnd_next;
    end
  end

endmodule

// File: tb/tb_random_digit.sv
// tb_random_digit: self-checking bench for random_digit.
//
// A behavioural model (polynomial parity + fold table) tracks the expected
// LFSR and digit; a compare process checks both DUTs (default SEED and
// SEED = 0) against it on every falling edge. Directed phases add literal
// expectations for reset, the first four digits, wrap after 65535 edges and an
// asynchronous mid-run reset.
module tb_random_digit;

  logic       clk;
  logic       reset;
  logic [3:0] rnd;
  logic [3:0] rnd_zero;

  int compared;
  int mismatched;

  // Model state
  logic [15:0] m_lfsr;
  logic [3:0]  m_rnd;
  bit          seen [10];

  random_digit dut (
    .clk   (clk),
    .reset (reset),
    .rnd   (rnd)
  );

  random_digit #(.SEED(16'h0000)) dut_zero (
    .clk   (clk),
    .reset (reset),
    .rnd   (rnd_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Feedback is the parity of the tapped bits 16,14,13,11 (mask 0xB400).
  function automatic logic [15:0] model_step(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  function automatic logic [3:0] model_fold(input logic [3:0] c);
    logic [3:0] table_v [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                 4'd8, 4'd9, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    return table_v[c];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr = 16'hACE1;
      m_rnd  = 4'd0;
    end else begin
      logic [3:0] d;
      m_lfsr = model_step(m_lfsr);
      d      = model_fold(m_lfsr[3:0]);
`ifdef RANDOM_DIGIT_NOREPEAT_EN
      if (d == m_rnd) d = 4'((int'(d) + 1) % 10);
`endif
      m_rnd  = d;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("rnd", {28'h0, rnd}, {28'h0, m_rnd});
    check("lfsr", {16'h0, dut.lfsr}, {16'h0, m_lfsr});
    check("rnd_seed0", {28'h0, rnd_zero}, {28'h0, m_rnd});
    check("lfsr_seed0", {16'h0, dut_zero.lfsr}, {16'h0, m_lfsr});
    check("rnd_range", {31'h0, (rnd > 4'd9)}, 32'h0);
    if (!reset && rnd <= 4'd9) seen[rnd] = 1'b1;
  end

  logic [15:0] exp_lfsr [4];
  logic [3:0]  exp_rnd  [4];

  task automatic check_first_four(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_rnd"}, {28'h0, rnd}, {28'h0, exp_rnd[i]});
      check({tag, "_lfsr"}, {16'h0, dut.lfsr}, {16'h0, exp_lfsr[i]});
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_lfsr   = '{16'h59C3, 16'hB387, 16'h670F, 16'hCE1E};
    exp_rnd    = '{4'd3, 4'd7, 4'd9, 4'd8};

    // Reset state is visible before any clock edge.
    reset = 1'b1;
    #1;
    check("reset_rnd_t0", {28'h0, rnd}, 32'h0);
    check("reset_lfsr_t0", {16'h0, dut.lfsr}, 32'hACE1);
    check("reset_lfsr_seed0_t0", {16'h0, dut_zero.lfsr}, 32'hACE1);

    // Reset held over several edges: state must not move.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold_rnd", {28'h0, rnd}, 32'h0);
    check("reset_hold_lfsr", {16'h0, dut.lfsr}, 32'hACE1);
    reset = 1'b0;

    check_first_four("first");

    // Remaining edges of the full period; LFSR must return to the seed.
    repeat (65531) @(posedge clk);
    @(negedge clk);
    check("wrap_lfsr", {16'h0, dut.lfsr}, 32'hACE1);
    check("wrap_lfsr_seed0", {16'h0, dut_zero.lfsr}, 32'hACE1);
    for (int d = 0; d < 10; d++) begin
      check($sformatf("digit_seen_%0d", d), {31'h0, seen[d]}, 32'h1);
    end
`ifndef RANDOM_DIGIT_NOREPEAT_EN
    check_first_four("after_wrap");
`endif

    // Asynchronous reset between edges mid-run.
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_rnd", {28'h0, rnd}, 32'h0);
    check("async_reset_lfsr", {16'h0, dut.lfsr}, 32'hACE1);
    check("async_reset_rnd_seed0", {28'h0, rnd_zero}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_first_four("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net: the stimulus is clock-driven, but never let the run hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
